// File: rtl/decoder_result_frame_parser.sv
// Parses decoder result frames (header, body words, 0xFFFFFFFF terminator) into one summary per frame.
// Optional statistics block is enabled by defining RESULT_PARSER_STATS_EN.
module decoder_result_frame_parser #(
    parameter int unsigned MAX_BODY_WORDS   = 4096,
    parameter int unsigned WORD_COUNT_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [31:0]                 in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        sum_valid,
    input  logic                        sum_ready,
    output logic [15:0]                 sum_cycles,
    output logic [7:0]                  sum_iters,
    output logic [WORD_COUNT_WIDTH-1:0] sum_words,
    output logic                        sum_overflow,
    output logic                        sum_timeout,
    output logic                        runt_pulse,
    input  logic                        stats_clear,
    output logic [31:0]                 stat_frames,
    output logic [15:0]                 stat_max_cyc,
    output logic [15:0]                 stat_errors
);

    localparam logic [31:0] TERM       = 32'hFFFF_FFFF;
    localparam int unsigned IDLE_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_BODY   = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    state_t                  state;
    logic [IDLE_WIDTH-1:0]   idle_cnt;
    logic                    xfer;
    logic                    is_term;
    logic                    idle_expire;

    assign xfer        = in_valid && in_ready;
    assign is_term     = (in_data == TERM);
    assign idle_expire = (TIMEOUT_CYCLES != 0) && ((32'(idle_cnt) + 32'd1) == TIMEOUT_CYCLES);

    // Frame FSM; in_ready is registered alongside state so it depends on state only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_HEADER;
            in_ready     <= 1'b0;
            sum_valid    <= 1'b0;
            sum_cycles   <= '0;
            sum_iters    <= '0;
            sum_words    <= '0;
            sum_overflow <= 1'b0;
            sum_timeout  <= 1'b0;
            runt_pulse   <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            runt_pulse <= 1'b0;
            case (state)
                ST_HEADER: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        if (is_term) begin
                            runt_pulse <= 1'b1;
                        end else begin
                            sum_cycles   <= in_data[15:0];
                            sum_iters    <= in_data[23:16];
                            sum_words    <= '0;
                            sum_overflow <= 1'b0;
                            sum_timeout  <= 1'b0;
                            idle_cnt     <= '0;
                            state        <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (is_term) begin
                            state     <= ST_EMIT;
                            sum_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            if (sum_words != '1) begin
                                sum_words <= sum_words + WORD_COUNT_WIDTH'(1);
                            end
                            // Overflow is flagged but the word is still consumed.
                            if (32'(sum_words) >= MAX_BODY_WORDS) begin
                                sum_overflow <= 1'b1;
                            end
                        end
                    end else if (idle_expire) begin
                        sum_timeout <= 1'b1;
                        state       <= ST_EMIT;
                        sum_valid   <= 1'b1;
                        in_ready    <= 1'b0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        idle_cnt <= idle_cnt + IDLE_WIDTH'(1);
                    end
                end
                ST_EMIT: begin
                    if (sum_ready) begin
                        state     <= ST_HEADER;
                        sum_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_HEADER;
                    sum_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef RESULT_PARSER_STATS_EN
    logic handoff;
    logic runt_evt;

    assign handoff  = sum_valid && sum_ready;
    assign runt_evt = xfer && is_term && (state == ST_HEADER);

    // Statistics; a clear wins over an update in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_frames  <= '0;
            stat_max_cyc <= '0;
            stat_errors  <= '0;
        end else if (stats_clear) begin
            stat_frames  <= '0;
            stat_max_cyc <= '0;
            stat_errors  <= '0;
        end else begin
            if (handoff) begin
                stat_frames <= stat_frames + 32'd1;
                if (sum_cycles > stat_max_cyc) begin
                    stat_max_cyc <= sum_cycles;
                end
            end
            if (((handoff && (sum_overflow || sum_timeout)) || runt_evt) && (stat_errors != 16'hFFFF)) begin
                stat_errors <= stat_errors + 16'd1;
            end
        end
    end
`else
    logic unused_stats_clear;

    assign unused_stats_clear = stats_clear;
    assign stat_frames        = '0;
    assign stat_max_cyc       = '0;
    assign stat_errors        = '0;
`endif

endmodule

// File: tb/tb_decoder_result_frame_parser.sv
// Directed bench for decoder_result_frame_parser: table of frames plus hand-written corner sequences.
module tb_decoder_result_frame_parser;

    localparam int unsigned MAXW = 8;
    localparam int unsigned WCW  = 4;
    localparam int unsigned TO   = 8;
    localparam logic [31:0] TERM = 32'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [31:0]     in_data;
    logic            in_valid;
    logic            in_ready;
    logic            sum_valid;
    logic            sum_ready;
    logic [15:0]     sum_cycles;
    logic [7:0]      sum_iters;
    logic [WCW-1:0]  sum_words;
    logic            sum_overflow;
    logic            sum_timeout;
    logic            runt_pulse;
    logic            stats_clear;
    logic [31:0]     stat_frames;
    logic [15:0]     stat_max_cyc;
    logic [15:0]     stat_errors;

    int checks = 0;
    int errors = 0;

    decoder_result_frame_parser #(
        .MAX_BODY_WORDS  (MAXW),
        .WORD_COUNT_WIDTH(WCW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .sum_cycles  (sum_cycles),
        .sum_iters   (sum_iters),
        .sum_words   (sum_words),
        .sum_overflow(sum_overflow),
        .sum_timeout (sum_timeout),
        .runt_pulse  (runt_pulse),
        .stats_clear (stats_clear),
        .stat_frames (stat_frames),
        .stat_max_cyc(stat_max_cyc),
        .stat_errors (stat_errors)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hdr;
        int          nbody;
        int          gap;
        bit          term;
        logic [15:0] cyc;
        logic [7:0]  iters;
        logic [3:0]  words;
        bit          ovf;
        bit          tmo;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word transferred.
    task automatic push(input logic [31:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input int nbody, input int gap, input bit term);
        push(hdr);
        for (int i = 0; i < nbody; i++) begin
            push(32'h0000_1000 + 32'(i));
            if (i == 0 && gap > 0) repeat (gap) @(negedge clk);
        end
        if (term) push(TERM);
    endtask

    task automatic wait_summary(output int waited);
        waited = 0;
        while (!sum_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("sum_valid_arrives", 32'(sum_valid), 32'd1);
    endtask

    task automatic expect_summary(input string tag, input logic [15:0] cyc, input logic [7:0] it,
                                  input logic [3:0] w, input bit ovf, input bit tmo);
        check({tag, "_cycles"},   32'(sum_cycles),   32'(cyc));
        check({tag, "_iters"},    32'(sum_iters),    32'(it));
        check({tag, "_words"},    32'(sum_words),    32'(w));
        check({tag, "_overflow"}, 32'(sum_overflow), 32'(ovf));
        check({tag, "_timeout"},  32'(sum_timeout),  32'(tmo));
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    task automatic handoff(input string tag);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        check({tag, "_valid_dropped"}, 32'(sum_valid), 32'd0);
        check({tag, "_ready_back"},    32'(in_ready),  32'd1);
    endtask

    initial begin
        int waited;
        logic [15:0] hold_cyc;
        logic [3:0]  hold_words;

        vecs[0] = '{32'h0003_0120, 5,  0, 1'b1, 16'h0120, 8'h03, 4'd5,  1'b0, 1'b0};
        vecs[1] = '{32'hAB7F_FFFE, 0,  0, 1'b1, 16'hFFFE, 8'h7F, 4'd0,  1'b0, 1'b0};
        vecs[2] = '{32'h0001_0010, 8,  0, 1'b1, 16'h0010, 8'h01, 4'd8,  1'b0, 1'b0};
        vecs[3] = '{32'h0002_0040, 9,  0, 1'b1, 16'h0040, 8'h02, 4'd9,  1'b1, 1'b0};
        vecs[4] = '{32'h0004_0020, 20, 0, 1'b1, 16'h0020, 8'h04, 4'd15, 1'b1, 1'b0};
        vecs[5] = '{32'h0005_0055, 3,  7, 1'b1, 16'h0055, 8'h05, 4'd3,  1'b0, 1'b0};
        vecs[6] = '{32'h0006_0066, 2,  0, 1'b0, 16'h0066, 8'h06, 4'd2,  1'b0, 1'b1};

        reset_n     = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        sum_ready   = 1'b0;
        stats_clear = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_cycles",    32'(sum_cycles), 32'd0);
        check("rst_words",     32'(sum_words), 32'd0);
        check("rst_runt",      32'(runt_pulse), 32'd0);
        check("rst_frames",    stat_frames, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Terminator in HEADER is a runt
        push(TERM);
        check("runt_pulse_hi", 32'(runt_pulse), 32'd1);
        check("runt_no_sum",   32'(sum_valid),  32'd0);
        @(negedge clk);
        check("runt_pulse_lo", 32'(runt_pulse), 32'd0);
`ifdef RESULT_PARSER_STATS_EN
        check("runt_stat_errors", 32'(stat_errors), 32'd1);
`else
        check("runt_stat_errors", 32'(stat_errors), 32'd0);
`endif

        // Table of frames
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].hdr, vecs[i].nbody, vecs[i].gap, vecs[i].term);
            wait_summary(waited);
            check($sformatf("v%0d_latency", i), 32'(waited), vecs[i].tmo ? TO : 32'd0);
            expect_summary($sformatf("v%0d", i), vecs[i].cyc, vecs[i].iters, vecs[i].words,
                           vecs[i].ovf, vecs[i].tmo);
            handoff($sformatf("v%0d", i));
        end

        // Late terminator after timeout close
        push(TERM);
        check("late_term_runt",   32'(runt_pulse), 32'd1);
        check("late_term_no_sum", 32'(sum_valid),  32'd0);
        @(negedge clk);

        // Held summary under back-pressure, then back-to-back frames
        send_frame(32'h0009_0099, 3, 0, 1'b1);
        wait_summary(waited);
        hold_cyc   = sum_cycles;
        hold_words = sum_words;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", c), 32'(sum_valid), 32'd1);
            check($sformatf("bp%0d_cycles", c), 32'(sum_cycles), 32'(hold_cyc));
            check($sformatf("bp%0d_words", c), 32'(sum_words), 32'(hold_words));
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        expect_summary("bp", 16'h0099, 8'h09, 4'd3, 1'b0, 1'b0);
        handoff("bp");
        send_frame(32'h000A_00AA, 1, 0, 1'b1);
        wait_summary(waited);
        expect_summary("b2b_a", 16'h00AA, 8'h0A, 4'd1, 1'b0, 1'b0);
        handoff("b2b_a");
        send_frame(32'h000B_00BB, 2, 0, 1'b1);
        wait_summary(waited);
        expect_summary("b2b_b", 16'h00BB, 8'h0B, 4'd2, 1'b0, 1'b0);
        handoff("b2b_b");

        // Reset in the middle of a frame
        push(32'h0007_0777);
        push(32'h0000_0001);
        push(32'h0000_0002);
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_sum_valid", 32'(sum_valid), 32'd0);
        check("midrst_cycles",    32'(sum_cycles), 32'd0);
        check("midrst_words",     32'(sum_words), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Three frames after reset feed the statistics
        send_frame(32'h0001_0010, 1, 0, 1'b1);
        wait_summary(waited);
        expect_summary("st0", 16'h0010, 8'h01, 4'd1, 1'b0, 1'b0);
        handoff("st0");
        send_frame(32'h0001_0040, 0, 0, 1'b1);
        wait_summary(waited);
        expect_summary("st1", 16'h0040, 8'h01, 4'd0, 1'b0, 1'b0);
        handoff("st1");
        send_frame(32'h0001_0020, 2, 0, 1'b1);
        wait_summary(waited);
        expect_summary("st2", 16'h0020, 8'h01, 4'd2, 1'b0, 1'b0);
        handoff("st2");
`ifdef RESULT_PARSER_STATS_EN
        check("stat_frames_3",  stat_frames, 32'd3);
        check("stat_max_cyc",   32'(stat_max_cyc), 32'h40);
        check("stat_errors_0",  32'(stat_errors), 32'd0);
`else
        check("stat_frames_off",  stat_frames, 32'd0);
        check("stat_max_cyc_off", 32'(stat_max_cyc), 32'd0);
        check("stat_errors_off",  32'(stat_errors), 32'd0);
`endif
        stats_clear = 1'b1;
        @(negedge clk);
        stats_clear = 1'b0;
        check("clr_frames",  stat_frames, 32'd0);
        check("clr_max_cyc", 32'(stat_max_cyc), 32'd0);
        check("clr_errors",  32'(stat_errors), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
